// File: rtl/alu16_sequencer.sv
// Sequences 16-bit ADD/SUB/XOR/AND/LSL/LSR operations as one-byte passes over an 8-bit combinational ALU.
// Carry and borrow are rebuilt from byte compares because the ALU does not report a carry-out.
module alu16_sequencer #(
  parameter int unsigned W_HALF = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [2*W_HALF-1:0]   a,
  input  logic [2*W_HALF-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [2*W_HALF-1:0]   result,
  output logic                  carry,
  output logic                  zero,
  output logic                  err,
  output logic [W_HALF-1:0]     alu_arg_0,
  output logic [W_HALF-1:0]     alu_arg_1,
  output logic [2:0]            alu_op_code,
  output logic                  data_signifier,
  output logic [1:0]            data_op_code,
  input  logic [W_HALF-1:0]     alu_out
);

  localparam int unsigned W_FULL = 2 * W_HALF;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P1   = 3'd2;
  localparam logic [2:0] S_P2   = 3'd3;
  localparam logic [2:0] S_P3   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_LSL = 3'd4;
  localparam logic [2:0] OP_LSR = 3'd5;

  localparam logic [2:0] K_ADD = 3'd0;
  localparam logic [2:0] K_SUB = 3'd1;
  localparam logic [2:0] K_XOR = 3'd2;
  localparam logic [2:0] K_AND = 3'd3;
  localparam logic [2:0] K_LSL = 3'd4;
  localparam logic [2:0] K_LSR = 3'd5;

  logic [2:0]        state, state_d;
  logic [2:0]        op_q, op_d;
  logic [W_FULL-1:0] a_q, a_d, b_q, b_d;
  logic [W_FULL-1:0] stage_q, stage_d;
  logic [W_HALF-1:0] t_q, t_d, s_q, s_d;
  logic              c_q, c_d, c1_q, c1_d;
  logic [W_FULL-1:0] result_d, fin_val;
  logic              carry_d, zero_d, err_d, fin, fin_carry;
  logic [W_HALF-1:0] arg0_d, arg1_d;
  logic [2:0]        alu_op_d;
  logic [W_HALF-1:0] n_ext, n_inv;
  logic              is_shift;

  function automatic logic [2:0] alu_code(input logic [2:0] o);
    case (o)
      OP_SUB:  alu_code = K_SUB;
      OP_XOR:  alu_code = K_XOR;
      OP_AND:  alu_code = K_AND;
      OP_LSL:  alu_code = K_LSL;
      OP_LSR:  alu_code = K_LSR;
      default: alu_code = K_ADD;
    endcase
  endfunction

  assign data_signifier = 1'b0;
  assign data_op_code   = 2'b00;

  // Next state, byte captures and final result assembly.
  always_comb begin
    state_d   = state;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    stage_d   = stage_q;
    t_d       = t_q;
    s_d       = s_q;
    c_d       = c_q;
    c1_d      = c1_q;
    result_d  = result;
    carry_d   = carry;
    zero_d    = zero;
    err_d     = err;
    fin       = 1'b0;
    fin_val   = '0;
    fin_carry = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
          if (op > OP_LSR) begin
            state_d  = S_DONE;
            result_d = '0;
            carry_d  = 1'b0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = S_P0;
          end
        end
      end
      S_P0: begin
        state_d = S_P1;
        if (op_q == OP_LSR) stage_d[W_FULL-1:W_HALF] = alu_out;
        else                stage_d[W_HALF-1:0]      = alu_out;
        c_d = (op_q == OP_SUB) ? (a_q[W_HALF-1:0] < b_q[W_HALF-1:0])
                               : (alu_out < a_q[W_HALF-1:0]);
      end
      S_P1: begin
        t_d  = alu_out;
        c1_d = (op_q == OP_SUB) ? (a_q[W_FULL-1:W_HALF] < b_q[W_FULL-1:W_HALF])
                                : (alu_out < a_q[W_FULL-1:W_HALF]);
        if (op_q == OP_XOR || op_q == OP_AND) begin
          state_d = S_DONE;
          fin     = 1'b1;
          fin_val = {alu_out, stage_q[W_HALF-1:0]};
        end else begin
          state_d = S_P2;
        end
      end
      S_P2: begin
        s_d = alu_out;
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          state_d   = S_DONE;
          fin       = 1'b1;
          fin_val   = {alu_out, stage_q[W_HALF-1:0]};
          fin_carry = (op_q == OP_SUB) ? (c1_q | (t_q < {{(W_HALF-1){1'b0}}, c_q}))
                                       : (c1_q | (alu_out < t_q));
        end else begin
          state_d = S_P3;
        end
      end
      S_P3: begin
        state_d = S_DONE;
        fin     = 1'b1;
        fin_val = (op_q == OP_LSR) ? {stage_q[W_FULL-1:W_HALF], alu_out}
                                   : {alu_out, stage_q[W_HALF-1:0]};
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      result_d = fin_val;
      carry_d  = fin_carry;
      zero_d   = (fin_val == '0);
      err_d    = 1'b0;
    end
  end

  assign n_ext    = W_HALF'(b_d[2:0]);
  assign n_inv    = W_HALF'(W_HALF) - n_ext;
  assign is_shift = (op_d == OP_LSL) || (op_d == OP_LSR);

  // ALU drive for the pass performed in the upcoming state, so the ALU ports come straight from flops.
  always_comb begin
    arg0_d   = '0;
    arg1_d   = '0;
    alu_op_d = K_ADD;
    case (state_d)
      S_P0: begin
        arg0_d   = (op_d == OP_LSR) ? a_d[W_FULL-1:W_HALF] : a_d[W_HALF-1:0];
        arg1_d   = is_shift ? n_ext : b_d[W_HALF-1:0];
        alu_op_d = alu_code(op_d);
      end
      S_P1: begin
        arg0_d   = (op_d == OP_LSR) ? a_d[W_HALF-1:0] : a_d[W_FULL-1:W_HALF];
        arg1_d   = is_shift ? n_ext : b_d[W_FULL-1:W_HALF];
        alu_op_d = alu_code(op_d);
      end
      S_P2: begin
        if (op_d == OP_LSL) begin
          arg0_d   = a_d[W_HALF-1:0];
          arg1_d   = n_inv;
          alu_op_d = K_LSR;
        end else if (op_d == OP_LSR) begin
          arg0_d   = a_d[W_FULL-1:W_HALF];
          arg1_d   = n_inv;
          alu_op_d = K_LSL;
        end else begin
          arg0_d   = t_d;
          arg1_d   = {{(W_HALF-1){1'b0}}, c_d};
          alu_op_d = alu_code(op_d);
        end
      end
      S_P3: begin
        // Shifted fields are disjoint, so XOR merges them like OR.
        arg0_d   = t_d;
        arg1_d   = s_d;
        alu_op_d = K_XOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      stage_q     <= '0;
      t_q         <= '0;
      s_q         <= '0;
      c_q         <= 1'b0;
      c1_q        <= 1'b0;
      result      <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      alu_arg_0   <= '0;
      alu_arg_1   <= '0;
      alu_op_code <= K_ADD;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      stage_q     <= stage_d;
      t_q         <= t_d;
      s_q         <= s_d;
      c_q         <= c_d;
      c1_q        <= c1_d;
      result      <= result_d;
      carry       <= carry_d;
      zero        <= zero_d;
      err         <= err_d;
      busy        <= (state_d != S_IDLE);
      done        <= (state_d == S_DONE);
      alu_arg_0   <= arg0_d;
      alu_arg_1   <= arg1_d;
      alu_op_code <= alu_op_d;
    end
  end

endmodule

// File: doc/alu16_sequencer.md
Name: alu16_sequencer

Overview:
- Multi-cycle controller that performs 16-bit operations on the 8-bit combinational ALU.
- It issues one ALU pass per clock and sequences LSW/MSW passes.
- It derives carry/borrow itself, because the ALU carry-out is always 0.
- It sits between the control unit (start/done handshake) and the ALU input/output ports, and owns the ALU for the duration of an operation.

Parameters:
- W_HALF, 8, ALU datapath width; the operand width is 2*W_HALF. Only 8 is supported.

Ports:
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  0 ADD16, 1 SUB16, 2 XOR16, 3 AND16, 4 LSL16, 5 LSR16, 6/7 illegal
- a  input  16  operand A
- b  input  16  operand B; for shifts, b[2:0] is the amount n (0..7) and b[15:3] is ignored
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result, carry, zero and err are valid from this cycle on
- result  output  16  registered result, held until the next accepted start
- carry  output  1  ADD16 carry-out or SUB16 borrow (1 = borrow); 0 for other ops
- zero  output  1  result == 0, registered with result
- err  output  1  illegal op flag, registered with result
- alu_arg_0  output  8  to ALU_arg_0
- alu_arg_1  output  8  to ALU_arg_1
- alu_op_code  output  3  to ALU_op_code (kADD/kSUB/kXOR/kAND/kLSL/kLSR codes)
- data_signifier  output  1  constant 0 (arithmetic path)
- data_op_code  output  2  constant 0
- alu_out  input  8  from ALU_out (combinational, same cycle)

Behaviour:
- Reset (async): state=IDLE, result=0, carry=0, zero=0, err=0, done=0, internal temporaries=0.
  - Reset mid-operation aborts: no done, and result keeps its reset value.
- States: IDLE, P0, P1, P2, P3, DONE. Each Pn state drives exactly one ALU pass and captures alu_out at the end of that cycle.
- Handshake:
  - start in IDLE latches a, b and op, then moves to P0 (or directly to DONE if op is illegal).
  - start in any other state is ignored; no queuing.
  - DONE lasts one cycle and then returns to IDLE.
  - A start arriving in the IDLE cycle right after DONE is accepted.
- In IDLE and DONE, the ALU outputs are driven to args=0 with op=kADD.
- Pass sequences (lo/hi are the byte halves of the latched operands; T and S are 8-bit temps; c is a 1-bit temp):
  - ADD16 (3 passes):
    - P0: lo_a+lo_b gives r_lo; c=(alu_out<lo_a).
    - P1: hi_a+hi_b gives T; c1=(alu_out<hi_a).
    - P2: T+{7'b0,c} gives r_hi; carry=c1|(alu_out<T).
  - SUB16 (3 passes):
    - P0: lo_a-lo_b gives r_lo; c=(lo_a<lo_b).
    - P1: hi_a-hi_b gives T; c1=(hi_a<hi_b).
    - P2: T-{7'b0,c} gives r_hi; carry=c1|(T<c).
  - XOR16/AND16 (2 passes):
    - P0: lo op lo.
    - P1: hi op hi.
    - carry=0.
  - LSL16 (4 passes):
    - P0: lo_a<<n gives r_lo.
    - P1: hi_a<<n gives T.
    - P2: lo_a>>(8-n) gives S; for n=0 the ALU is driven with shift amount 8, giving 0.
    - P3: T^S gives r_hi. XOR acts as OR because the bit fields are disjoint.
  - LSR16 (4 passes):
    - P0: hi_a>>n gives r_hi.
    - P1: lo_a>>n gives T.
    - P2: hi_a<<(8-n) gives S.
    - P3: T^S gives r_lo.
- Latency, from the start edge to the done cycle:
  - 4 cycles for ADD/SUB.
  - 3 cycles for XOR/AND.
  - 5 cycles for shifts.
  - 1 cycle for illegal ops.
- Result update:
  - result, carry and zero update on the edge entering DONE.
  - The partial r_lo/r_hi live in a staging register, so result never shows partial values.
- Illegal op: result=0, carry=0, zero=1, err=1.
- err is cleared on the next legal start, when that operation completes.
- Operands are latched at start, so changes on a/b/op while busy have no effect.

Test Plan:
- ADD16 a=0x12FF b=0x0001 -> done on the 4th cycle after start; result=0x1300, carry=0, zero=0, busy high for 4 cycles.
- ADD16 a=0xFFFF b=0x0001 -> result=0x0000, carry=1, zero=1. ADD16 a=0x80FF b=0x80FF -> result=0x01FE, carry=1.
- SUB16 a=0x1000 b=0x0001 -> result=0x0FFF, carry=0. SUB16 a=0x0000 b=0x0001 -> result=0xFFFF, carry=1.
- Shift cases, each with done after 5 cycles:
  - LSL16 a=0x81C3 n=3 -> 0x0E18.
  - LSR16 a=0x81C3 n=4 -> 0x081C.
  - LSL16 n=0 -> result equals a.
  - XOR16 0xF0F0^0xFF00 -> 0x0FF0 after 3 cycles.
- op=6 -> done on the next cycle, err=1, result=0. A subsequent AND16 0xFFFF&0x00FF -> 0x00FF with err=0.
- Reset and handshake edge cases:
  - Start ADD16, assert Reset during P1 -> immediate IDLE, busy=0, result=0, no done pulse.
  - start pulsed while busy -> ignored, with the original result intact.
  - Back-to-back start in the IDLE cycle after DONE -> accepted.
